rom_dl_router: RTL and testbench

- Sits between the HPS ioctl download stream and the burnin_rubber game core.
- Decodes the flat ROM image into per-region write strobes and region-relative addresses for the CPU, sound, graphics and PROM memories.
- Holds the game in reset until the image is fully and correctly loaded, plus a settle delay.
- Reports load status for LED and OSD use.

---
 rtl/rom_dl_router.sv | 246 ++++++++++++++++++++++++
 tb/tb_rom_dl_router.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_router.sv
// Routes the HPS ioctl ROM download into per-region write strobes and holds the game core
// in reset until a complete, in-order image has loaded. Optional checksum gate: ROM_CHECKSUM_EN.
module rom_dl_router #(
    parameter logic [16:0] SND_BASE   = 17'h0C000,
    parameter logic [16:0] GFX_BASE   = 17'h0E000,
    parameter logic [16:0] PROM_BASE  = 17'h1A000,
    parameter logic [16:0] TOTAL_SIZE = 17'h1A040,
    parameter int unsigned SETTLE_CYC = 16
`ifdef ROM_CHECKSUM_EN
    ,
    parameter logic [15:0] EXPECTED_SUM = 16'h0000
`endif
) (
    input  logic        clock_12,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [16:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        cpu_rom_we,
    output logic        snd_rom_we,
    output logic        gfx_rom_we,
    output logic        prom_we,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        game_reset,
    output logic        load_ok,
    output logic        load_err,
`ifdef ROM_CHECKSUM_EN
    output logic        sum_ok,
`endif
    output logic [16:0] byte_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam int unsigned      SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [16:0]      CNT_MAX  = 17'h1FFFF;

    state_t           state_q, state_d;
    logic             act_q;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [16:0]      count_q, count_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             game_reset_q, game_reset_d;
    logic [3:0]       we_q, we_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;

    logic             act_rise;
    logic             act_fall;
    logic             accept;
    logic             in_range;
    logic             start_load;
    logic             sum_match;
    logic [3:0]       region;
    logic [15:0]      base;

    assign act_rise   = dl_active & ~act_q;
    assign act_fall   = ~dl_active & act_q;
    // The cycle dl_active falls still belongs to the download, so its byte is taken too.
    assign accept     = (state_q == ST_LOAD) & dl_wr & (dl_active | act_q);
    assign start_load = act_rise & (state_q != ST_LOAD);
    assign in_range   = |region;

    // Region decode: one-hot {cpu, snd, gfx, prom} select and region base.
    always_comb begin
        region = 4'b0000;
        base   = 16'h0000;
        if (dl_addr < SND_BASE) begin
            region = 4'b1000;
            base   = 16'h0000;
        end else if (dl_addr < GFX_BASE) begin
            region = 4'b0100;
            base   = SND_BASE[15:0];
        end else if (dl_addr < PROM_BASE) begin
            region = 4'b0010;
            base   = GFX_BASE[15:0];
        end else if (dl_addr < TOTAL_SIZE) begin
            region = 4'b0001;
            base   = PROM_BASE[15:0];
        end else begin
            region = 4'b0000;
            base   = PROM_BASE[15:0];
        end
    end

    // Write path: strobe, relative address and data for an accepted in-range byte.
    always_comb begin
        we_d   = 4'b0000;
        addr_d = addr_q;
        data_d = data_q;
        if (accept && in_range) begin
            we_d   = region;
            addr_d = dl_addr[15:0] - base;
            data_d = dl_data;
        end else begin
            we_d   = 4'b0000;
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic        sum_ok_q, sum_ok_d;

    // Running byte sum and the match flag latched at completion.
    always_comb begin
        sum_d    = sum_q;
        sum_ok_d = sum_ok_q;
        if (start_load) begin
            sum_d    = 16'h0000;
            sum_ok_d = 1'b0;
        end else if (accept && in_range) begin
            sum_d    = sum_q + {8'h00, dl_data};
        end else begin
            sum_d    = sum_q;
        end
        sum_match = (sum_d == EXPECTED_SUM);
        if ((state_q == ST_LOAD) && act_fall) begin
            sum_ok_d = sum_match;
        end else begin
            sum_ok_d = sum_ok_d;
        end
    end

    // Checksum registers.
    always_ff @(posedge clock_12) begin
        if (reset) begin
            sum_q    <= 16'h0000;
            sum_ok_q <= 1'b0;
        end else begin
            sum_q    <= sum_d;
            sum_ok_q <= sum_ok_d;
        end
    end

    assign sum_ok = sum_ok_q;
`else
    assign sum_match = 1'b1;
`endif

    // Load FSM next state, byte counter and status flags.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        count_d  = count_q;
        ok_d     = ok_q;
        err_d    = err_q;
        if (accept) begin
            count_d = (count_q == CNT_MAX) ? count_q : count_q + 17'd1;
            if ((dl_addr != count_q) || !in_range) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            count_d = count_q;
        end
        case (state_q)
            ST_IDLE: begin
                state_d = start_load ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                if (act_fall) begin
                    if ((count_d == TOTAL_SIZE) && !err_d && sum_match) begin
                        state_d  = ST_SETTLE;
                        settle_d = {SET_W{1'b0}};
                    end else begin
                        err_d    = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SETTLE: begin
                if (start_load) begin
                    state_d = ST_LOAD;
                end else if (settle_q == SET_LAST) begin
                    ok_d    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_RUN: begin
                state_d = start_load ? ST_LOAD : ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start_load) begin
            count_d = 17'h00000;
            ok_d    = 1'b0;
            err_d   = 1'b0;
        end else begin
            count_d = count_d;
        end
        game_reset_d = (state_d != ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clock_12) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            // Track the input during reset so a download already in flight is not seen as a new one.
            act_q        <= dl_active;
            settle_q     <= {SET_W{1'b0}};
            count_q      <= 17'h00000;
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
            game_reset_q <= 1'b1;
            we_q         <= 4'b0000;
            addr_q       <= 16'h0000;
            data_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            act_q        <= dl_active;
            settle_q     <= settle_d;
            count_q      <= count_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
            game_reset_q <= game_reset_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign {cpu_rom_we, snd_rom_we, gfx_rom_we, prom_we} = we_q;
    assign rom_addr   = addr_q;
    assign rom_data   = data_q;
    assign game_reset = game_reset_q;
    assign load_ok    = ok_q;
    assign load_err   = err_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_rom_dl_router.sv
// Scoreboard bench for rom_dl_router: a shrunken-image instance for full loads and a
// default-parameter instance for the real region boundaries.
module tb_rom_dl_router;

    localparam logic [16:0] S_SND  = 17'h000C0;
    localparam logic [16:0] S_GFX  = 17'h000E0;
    localparam logic [16:0] S_PROM = 17'h001A0;
    localparam logic [16:0] S_TS   = 17'h001A4;
    localparam int          SETTLE = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, dl_active, dl_wr;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;

    logic        cpu_we, snd_we, gfx_we, prom_we, game_reset, load_ok, load_err;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [16:0] byte_count;
    logic        b_cpu_we, b_snd_we, b_gfx_we, b_prom_we, b_game_reset, b_load_ok, b_load_err;
    logic [15:0] b_rom_addr;
    logic [7:0]  b_rom_data;
    logic [16:0] b_byte_count;
`ifdef ROM_CHECKSUM_EN
    logic        sum_ok, b_sum_ok;
    int          mode_ok = 1;
`else
    int          mode_ok = 0;
`endif

    rom_dl_router #(
        .SND_BASE(S_SND), .GFX_BASE(S_GFX), .PROM_BASE(S_PROM), .TOTAL_SIZE(S_TS), .SETTLE_CYC(SETTLE)
`ifdef ROM_CHECKSUM_EN
        , .EXPECTED_SUM(16'h1234)
`endif
    ) u_dut (
        .clock_12(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data),
        .cpu_rom_we(cpu_we), .snd_rom_we(snd_we), .gfx_rom_we(gfx_we), .prom_we(prom_we),
        .rom_addr(rom_addr), .rom_data(rom_data), .game_reset(game_reset),
        .load_ok(load_ok), .load_err(load_err),
`ifdef ROM_CHECKSUM_EN
        .sum_ok(sum_ok),
`endif
        .byte_count(byte_count)
    );

    rom_dl_router u_dut_full (
        .clock_12(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data),
        .cpu_rom_we(b_cpu_we), .snd_rom_we(b_snd_we), .gfx_rom_we(b_gfx_we), .prom_we(b_prom_we),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data), .game_reset(b_game_reset),
        .load_ok(b_load_ok), .load_err(b_load_err),
`ifdef ROM_CHECKSUM_EN
        .sum_ok(b_sum_ok),
`endif
        .byte_count(b_byte_count)
    );

    typedef struct packed {
        logic [3:0]  we;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   strobes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe from the small instance must match the oldest expected write.
    always @(negedge clk) begin : mon
        logic [3:0] we_v;
        exp_t       e;
        we_v = {cpu_we, snd_we, gfx_we, prom_we};
        if (we_v !== 4'b0000) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe got we=%b addr=%h, expected no strobe", we_v, rom_addr);
            end else begin
                e = exp_q.pop_front();
                strobes++;
                if ({we_v, rom_addr, rom_data, 32'(cyc)} !== {e.we, e.addr, e.data, e.cyc}) begin
                    bad++;
                    $display("FAIL strobe got we=%b addr=%h data=%h cyc=%0d, expected we=%b addr=%h data=%h cyc=%0d",
                             we_v, rom_addr, rom_data, cyc, e.we, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    function automatic logic [3:0] exp_we(input logic [16:0] a);
        if (a < S_SND) return 4'b1000;
        else if (a < S_GFX) return 4'b0100;
        else if (a < S_PROM) return 4'b0010;
        else return 4'b0001;
    endfunction

    function automatic logic [15:0] exp_off(input logic [16:0] a);
        logic [16:0] o;
        if (a < S_SND) o = a;
        else if (a < S_GFX) o = a - S_SND;
        else if (a < S_PROM) o = a - S_GFX;
        else o = a - S_PROM;
        return o[15:0];
    endfunction

    // Mode 0: address pattern; modes 1/2: images summing to 0x1234 / 0x1235.
    function automatic logic [7:0] img_byte(input logic [16:0] a, input int mode);
        if (mode == 0) return a[7:0] ^ 8'hA5;
        if (a < 17'd18) return 8'hFF;
        if (a == 17'd18) return (mode == 1) ? 8'h46 : 8'h47;
        return 8'h00;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [16:0] a, input logic [7:0] d, input logic last, input logic track);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        if (last) dl_active = 1'b0;
        if (track && (a < S_TS)) exp_q.push_back('{we: exp_we(a), addr: exp_off(a), data: d, cyc: 32'(cyc + 1)});
        tick(1);
        dl_wr = 1'b0;
    endtask

    task automatic load(input int n, input int skip, input int extra, input logic drop_last, input int mode);
        int a = 0;
        dl_active = 1'b1;
        tick(1);
        for (int k = 0; k < n; k++) begin
            if (a == skip) a++;
            wr(17'(a), img_byte(17'(a), mode), drop_last && (k == n - 1), 1'b1);
            a++;
        end
        if (extra >= 0) wr(17'(extra), img_byte(17'(extra), mode), 1'b0, 1'b1);
        dl_active = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = 17'h0; dl_data = 8'h00;
        tick(3);
        total++;
        if ({cpu_we, snd_we, gfx_we, prom_we, rom_addr, rom_data} !== {4'b0000, 16'h0000, 8'h00}) begin
            bad++; $display("FAIL reset_write_path got %b/%h/%h, expected 0000/0000/00",
                            {cpu_we, snd_we, gfx_we, prom_we}, rom_addr, rom_data);
        end
        total++;
        if ({game_reset, load_ok, load_err, byte_count} !== {1'b1, 1'b0, 1'b0, 17'h0}) begin
            bad++; $display("FAIL reset_status got rst=%b ok=%b err=%b cnt=%h, expected 1 0 0 0",
                            game_reset, load_ok, load_err, byte_count);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_full_load();
        int s0 = strobes;
        load(int'(S_TS), -1, -1, 1'b1, mode_ok);
        tick(SETTLE - 1);
        total++;
        if (game_reset !== 1'b1) begin
            bad++; $display("FAIL settle_hold got game_reset=%b, expected 1", game_reset);
        end
        tick(1);
        total++;
        if ({game_reset, load_ok, load_err, byte_count} !== {1'b0, 1'b1, 1'b0, S_TS}) begin
            bad++; $display("FAIL full_load got rst=%b ok=%b err=%b cnt=%h, expected 0 1 0 %h",
                            game_reset, load_ok, load_err, byte_count, S_TS);
        end
        total++;
        if ((strobes - s0 != int'(S_TS)) || (exp_q.size() != 0)) begin
            bad++; $display("FAIL full_strobes got %0d (pending %0d), expected %0d", strobes - s0, exp_q.size(), S_TS);
            exp_q.delete();
        end
    endtask

    task automatic test_idle_wr();
        dl_wr = 1'b1; dl_addr = 17'h0; dl_data = 8'h11;
        tick(1);
        dl_wr = 1'b0;
        tick(1);
        total++;
        if ({byte_count, game_reset} !== {S_TS, 1'b0}) begin
            bad++; $display("FAIL idle_wr got cnt=%h rst=%b, expected %h 0", byte_count, game_reset, S_TS);
        end
    endtask

    task automatic test_redownload_run();
        dl_active = 1'b1;
        tick(1);
        total++;
        if ({game_reset, load_ok, load_err, byte_count} !== {1'b1, 1'b0, 1'b0, 17'h0}) begin
            bad++; $display("FAIL redl_run got rst=%b ok=%b err=%b cnt=%h, expected 1 0 0 0",
                            game_reset, load_ok, load_err, byte_count);
        end
        dl_active = 1'b0;
        tick(2);
    endtask

    task automatic test_short();
        load(256, -1, -1, 1'b0, mode_ok);
        tick(3);
        total++;
        if ({game_reset, load_ok, load_err, byte_count} !== {1'b1, 1'b0, 1'b1, 17'h00100}) begin
            bad++; $display("FAIL short_load got rst=%b ok=%b err=%b cnt=%h, expected 1 0 1 00100",
                            game_reset, load_ok, load_err, byte_count);
        end
        tick(SETTLE + 4);
        total++;
        if (game_reset !== 1'b1) begin
            bad++; $display("FAIL short_hold got game_reset=%b, expected 1", game_reset);
        end
    endtask

    task automatic test_regions();
        logic [16:0] addrs [5] = '{17'h0BFFF, 17'h0C000, 17'h0DFFF, 17'h0E000, 17'h1A000};
        logic [3:0]  wes   [5] = '{4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0001};
        logic [15:0] offs  [5] = '{16'hBFFF, 16'h0000, 16'h1FFF, 16'h0000, 16'h0000};
        dl_active = 1'b1;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            wr(addrs[i], 8'(8'h30 + i), 1'b0, 1'b1);
            total++;
            if ({b_cpu_we, b_snd_we, b_gfx_we, b_prom_we, b_rom_addr, b_rom_data} !== {wes[i], offs[i], 8'(8'h30 + i)}) begin
                bad++; $display("FAIL region_%0d got we=%b addr=%h data=%h, expected we=%b addr=%h data=%h", i,
                                {b_cpu_we, b_snd_we, b_gfx_we, b_prom_we}, b_rom_addr, b_rom_data,
                                wes[i], offs[i], 8'(8'h30 + i));
            end
        end
        wr(17'h1A040, 8'h77, 1'b0, 1'b1);
        total++;
        if ({b_cpu_we, b_snd_we, b_gfx_we, b_prom_we} !== 4'b0000) begin
            bad++; $display("FAIL region_oversize got we=%b, expected 0000", {b_cpu_we, b_snd_we, b_gfx_we, b_prom_we});
        end
        dl_active = 1'b0;
        tick(2);
        total++;
        if ({b_load_err, b_byte_count} !== {1'b1, 17'd6}) begin
            bad++; $display("FAIL region_status got err=%b cnt=%h, expected 1 00006", b_load_err, b_byte_count);
        end
    endtask

    task automatic test_oversize();
        load(int'(S_TS), -1, int'(S_TS), 1'b0, mode_ok);
        tick(3);
        total++;
        if ({game_reset, load_ok, load_err, byte_count} !== {1'b1, 1'b0, 1'b1, S_TS + 17'd1}) begin
            bad++; $display("FAIL oversize got rst=%b ok=%b err=%b cnt=%h, expected 1 0 1 %h",
                            game_reset, load_ok, load_err, byte_count, S_TS + 17'd1);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL oversize_strobes got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_skip();
        load(int'(S_TS) - 1, 5, 5, 1'b0, mode_ok);
        tick(3);
        total++;
        if ({game_reset, load_ok, load_err, byte_count} !== {1'b1, 1'b0, 1'b1, S_TS}) begin
            bad++; $display("FAIL skip_addr got rst=%b ok=%b err=%b cnt=%h, expected 1 0 1 %h",
                            game_reset, load_ok, load_err, byte_count, S_TS);
        end
    endtask

    task automatic test_abort_settle();
        load(int'(S_TS), -1, -1, 1'b1, mode_ok);
        tick(5);
        dl_active = 1'b1;
        tick(1);
        total++;
        if ({game_reset, load_ok, load_err, byte_count} !== {1'b1, 1'b0, 1'b0, 17'h0}) begin
            bad++; $display("FAIL abort_settle got rst=%b ok=%b err=%b cnt=%h, expected 1 0 0 0",
                            game_reset, load_ok, load_err, byte_count);
        end
        dl_active = 1'b0;
        tick(SETTLE + 5);
        total++;
        if ({game_reset, load_err} !== {1'b1, 1'b1}) begin
            bad++; $display("FAIL abort_reload got rst=%b err=%b, expected 1 1", game_reset, load_err);
        end
    endtask

    task automatic test_reset_mid();
        dl_active = 1'b1;
        tick(1);
        for (int a = 0; a < 3; a++) wr(17'(a), img_byte(17'(a), mode_ok), 1'b0, 1'b1);
        tick(1);
        reset = 1'b1;
        tick(2);
        total++;
        if ({game_reset, load_err, byte_count} !== {1'b1, 1'b0, 17'h0}) begin
            bad++; $display("FAIL reset_mid got rst=%b err=%b cnt=%h, expected 1 0 0", game_reset, load_err, byte_count);
        end
        reset = 1'b0;
        wr(17'd3, 8'h5C, 1'b0, 1'b0);
        wr(17'd4, 8'h5D, 1'b0, 1'b0);
        tick(1);
        dl_active = 1'b0;
        tick(2);
        total++;
        if ({game_reset, load_err, byte_count} !== {1'b1, 1'b0, 17'h0}) begin
            bad++; $display("FAIL reset_untracked got rst=%b err=%b cnt=%h, expected 1 0 0", game_reset, load_err, byte_count);
        end
    endtask

    task automatic test_back_to_back();
        load(int'(S_TS), -1, -1, 1'b1, mode_ok);
        tick(SETTLE);
        total++;
        if ({game_reset, load_ok, load_err, byte_count} !== {1'b0, 1'b1, 1'b0, S_TS}) begin
            bad++; $display("FAIL recover_load got rst=%b ok=%b err=%b cnt=%h, expected 0 1 0 %h",
                            game_reset, load_ok, load_err, byte_count, S_TS);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL pending_strobes got %0d, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

`ifdef ROM_CHECKSUM_EN
    task automatic test_checksum();
        load(int'(S_TS), -1, -1, 1'b1, 2);
        tick(SETTLE + 4);
        total++;
        if ({game_reset, load_ok, load_err, sum_ok} !== {1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL sum_bad got rst=%b ok=%b err=%b sum_ok=%b, expected 1 0 1 0",
                            game_reset, load_ok, load_err, sum_ok);
        end
        load(int'(S_TS), -1, -1, 1'b1, 1);
        tick(SETTLE);
        total++;
        if ({game_reset, load_ok, load_err, sum_ok} !== {1'b0, 1'b1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL sum_good got rst=%b ok=%b err=%b sum_ok=%b, expected 0 1 0 1",
                            game_reset, load_ok, load_err, sum_ok);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_idle_wr();
        test_redownload_run();
        test_short();
        test_regions();
        test_oversize();
        test_skip();
        test_abort_settle();
        test_reset_mid();
        test_back_to_back();
`ifdef ROM_CHECKSUM_EN
        test_checksum();
`endif
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
